// File: rtl/drfm_pkg.sv
// Shared definitions for the Doppler sweep controller: sweep states,
// default widths/latency and the packed sweep-profile record.
package drfm_pkg;

  localparam int DFLT_INC_W         = 32;
  localparam int DFLT_CNT_W         = 16;
  localparam int DFLT_SHIFT_LATENCY = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sweep_state_e;

  // Profile as held in the shadow registers; step is two's complement.
  typedef struct packed {
    logic [DFLT_INC_W-1:0] start_inc;
    logic [DFLT_INC_W-1:0] step;
    logic [DFLT_CNT_W-1:0] num_steps;
    logic [DFLT_CNT_W-1:0] dwell;
  } sweep_cfg_t;

  // A programmed count of zero behaves as one.
  function automatic logic [DFLT_CNT_W-1:0] at_least_one(input logic [DFLT_CNT_W-1:0] v);
    return (v == '0) ? DFLT_CNT_W'(1) : v;
  endfunction

endpackage

// File: rtl/doppler_sweep_ctrl_if.sv
// Profile-load bus between radar control (master) and the sweep
// controller (slave). Transfer happens on cfg_valid & cfg_ready.
interface doppler_sweep_ctrl_if
  import drfm_pkg::*;
#(
  parameter int INC_W = DFLT_INC_W,
  parameter int CNT_W = DFLT_CNT_W
) ();

  logic             cfg_valid;
  logic             cfg_ready;
  logic [INC_W-1:0] cfg_start_inc;
  logic [INC_W-1:0] cfg_step;
  logic [CNT_W-1:0] cfg_num_steps;
  logic [CNT_W-1:0] cfg_dwell;

  modport master (
    output cfg_valid, cfg_start_inc, cfg_step, cfg_num_steps, cfg_dwell,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_start_inc, cfg_step, cfg_num_steps, cfg_dwell,
    output cfg_ready
  );

endinterface

// File: rtl/valid_delay_line.sv
// Parameterised-depth 1-bit shift register with synchronous clear;
// q_o is d_i delayed by DEPTH clock edges.
module valid_delay_line #(
  parameter int DEPTH = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] sr_q;

  // Shift one stage per clock; reset and clear both flush every stage.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      sr_q <= '0;
    end else begin
      sr_q[0] <= d_i;
      for (int k = 1; k < DEPTH; k++) begin
        sr_q[k] <= sr_q[k-1];
      end
    end
  end

  assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/doppler_sweep_ctrl.sv
// Doppler sweep sequencer: drives the NCO phase increment through a
// programmed ramp, one increment value per dwell of input samples, and
// produces the shifter-output valid strobe.
// Optional build macro DOPPLER_TRIANGLE_EN: after the up-ramp, ramp back
// down to the start increment before draining.
module doppler_sweep_ctrl
  import drfm_pkg::*;
#(
  parameter int SHIFT_LATENCY = DFLT_SHIFT_LATENCY,
  parameter int INC_W         = DFLT_INC_W,
  parameter int CNT_W         = DFLT_CNT_W
) (
  input  logic                 M100CLK,
  input  logic                 reset,
  doppler_sweep_ctrl_if.slave  cfg,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 input_ready,
  output logic [INC_W-1:0]     phase_inc,
  output logic                 nco_en,
  output logic                 shifted_valid,
  output logic [CNT_W-1:0]     step_idx,
  output logic                 busy,
  output logic                 done
);

  localparam int DRAIN_W = (SHIFT_LATENCY > 1) ? $clog2(SHIFT_LATENCY) : 1;

  sweep_state_e        state_q, state_d;
  sweep_cfg_t          cfg_q, cfg_d, cfg_in;
  logic                cfg_loaded_q, cfg_loaded_d;
  logic [INC_W-1:0]    phase_inc_q, phase_inc_d;
  logic [CNT_W-1:0]    step_idx_q, step_idx_d;
  logic [CNT_W-1:0]    dwell_cnt_q, dwell_cnt_d;
  logic [DRAIN_W-1:0]  drain_cnt_q, drain_cnt_d;
`ifdef DOPPLER_TRIANGLE_EN
  logic                dir_down_q, dir_down_d;
  logic [CNT_W:0]      tri_last_idx;
`endif

  logic                cfg_xfer;
  logic                abort_act;
  logic [CNT_W-1:0]    ns_eff, dwell_eff;
  logic                last_step, dwell_end;
  logic signed [INC_W-1:0] phase_s, step_s, phase_up, phase_dn;

  assign cfg.cfg_ready = (state_q == ST_IDLE) && !reset;
  assign cfg_xfer      = cfg.cfg_valid && cfg.cfg_ready;
  assign cfg_in        = '{start_inc: cfg.cfg_start_inc, step: cfg.cfg_step,
                           num_steps: cfg.cfg_num_steps, dwell: cfg.cfg_dwell};
  assign abort_act     = abort && ((state_q == ST_RUN) || (state_q == ST_DRAIN));

  assign ns_eff    = at_least_one(cfg_q.num_steps);
  assign dwell_eff = at_least_one(cfg_q.dwell);
  assign last_step = (step_idx_q == ns_eff - CNT_W'(1));
  assign dwell_end = (dwell_cnt_q == dwell_eff - CNT_W'(1));

  // Increment arithmetic wraps modulo 2^INC_W.
  assign phase_s  = $signed(phase_inc_q);
  assign step_s   = $signed(cfg_q.step);
  assign phase_up = phase_s + step_s;
  assign phase_dn = phase_s - step_s;
`ifdef DOPPLER_TRIANGLE_EN
  // Final index of the triangle is 2*(num_steps-1).
  assign tri_last_idx = {ns_eff - CNT_W'(1), 1'b0};
`endif

  // Sweep sequencing: profile capture, ramp stepping, drain and completion.
  always_comb begin
    state_d      = state_q;
    cfg_d        = cfg_q;
    cfg_loaded_d = cfg_loaded_q;
    phase_inc_d  = phase_inc_q;
    step_idx_d   = step_idx_q;
    dwell_cnt_d  = dwell_cnt_q;
    drain_cnt_d  = drain_cnt_q;
`ifdef DOPPLER_TRIANGLE_EN
    dir_down_d   = dir_down_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cfg_xfer) begin
          cfg_d        = cfg_in;
          cfg_loaded_d = 1'b1;
        end
        if (start && (cfg_xfer || cfg_loaded_q)) begin
          state_d     = ST_RUN;
          phase_inc_d = cfg_xfer ? cfg_in.start_inc : cfg_q.start_inc;
          step_idx_d  = '0;
          dwell_cnt_d = '0;
`ifdef DOPPLER_TRIANGLE_EN
          dir_down_d  = 1'b0;
`endif
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d     = ST_IDLE;
          phase_inc_d = '0;
        end else if (input_ready) begin
          if (dwell_end) begin
            dwell_cnt_d = '0;
`ifdef DOPPLER_TRIANGLE_EN
            if (!dir_down_q && !last_step) begin
              step_idx_d  = step_idx_q + CNT_W'(1);
              phase_inc_d = $unsigned(phase_up);
            end else if (!dir_down_q && (ns_eff != CNT_W'(1))) begin
              dir_down_d  = 1'b1;
              step_idx_d  = step_idx_q + CNT_W'(1);
              phase_inc_d = $unsigned(phase_dn);
            end else if (dir_down_q && ({1'b0, step_idx_q} != tri_last_idx)) begin
              step_idx_d  = step_idx_q + CNT_W'(1);
              phase_inc_d = $unsigned(phase_dn);
            end else begin
              state_d     = ST_DRAIN;
              drain_cnt_d = '0;
            end
`else
            if (last_step) begin
              state_d     = ST_DRAIN;
              drain_cnt_d = '0;
            end else begin
              step_idx_d  = step_idx_q + CNT_W'(1);
              phase_inc_d = $unsigned(phase_up);
            end
`endif
          end else begin
            dwell_cnt_d = dwell_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          state_d     = ST_IDLE;
          phase_inc_d = '0;
        end else if (drain_cnt_q == DRAIN_W'(SHIFT_LATENCY - 1)) begin
          state_d = ST_DONE;
        end else begin
          drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and profile registers; reset clears everything including shadows.
  always_ff @(posedge M100CLK) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cfg_q        <= '0;
      cfg_loaded_q <= 1'b0;
      phase_inc_q  <= '0;
      step_idx_q   <= '0;
      dwell_cnt_q  <= '0;
      drain_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      cfg_q        <= cfg_d;
      cfg_loaded_q <= cfg_loaded_d;
      phase_inc_q  <= phase_inc_d;
      step_idx_q   <= step_idx_d;
      dwell_cnt_q  <= dwell_cnt_d;
      drain_cnt_q  <= drain_cnt_d;
    end
  end

`ifdef DOPPLER_TRIANGLE_EN
  // Ramp direction for the triangle profile; starts on the up-ramp.
  always_ff @(posedge M100CLK) begin
    if (reset) dir_down_q <= 1'b0;
    else       dir_down_q <= dir_down_d;
  end
`endif

  // Valid strobe tracks the shifter's register pipeline; abort flushes it.
  valid_delay_line #(.DEPTH(SHIFT_LATENCY)) u_vld_dly (
    .clk_i (M100CLK),
    .rst_i (reset),
    .clr_i (abort_act),
    .d_i   (input_ready && nco_en),
    .q_o   (shifted_valid)
  );

  assign phase_inc = phase_inc_q;
  assign step_idx  = step_idx_q;
  assign nco_en    = (state_q == ST_RUN);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_doppler_sweep_ctrl.sv
// Directed bench for doppler_sweep_ctrl with hand-computed expectations.
module tb_doppler_sweep_ctrl;
  import drfm_pkg::*;

  logic        M100CLK = 1'b0;
  logic        reset;
  logic        start, abort, input_ready;
  logic [31:0] phase_inc;
  logic        nco_en, shifted_valid, busy, done;
  logic [15:0] step_idx;

  int n_chk  = 0;
  int n_pass = 0;
  int sv_cnt = 0;
  int done_cnt = 0;
  int base;

  doppler_sweep_ctrl_if cfg_if ();

  doppler_sweep_ctrl dut (
    .M100CLK       (M100CLK),
    .reset         (reset),
    .cfg           (cfg_if),
    .start         (start),
    .abort         (abort),
    .input_ready   (input_ready),
    .phase_inc     (phase_inc),
    .nco_en        (nco_en),
    .shifted_valid (shifted_valid),
    .step_idx      (step_idx),
    .busy          (busy),
    .done          (done)
  );

  always #5 M100CLK = ~M100CLK;

  always @(negedge M100CLK) begin
    if (shifted_valid) sv_cnt++;
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge M100CLK);
    #1;
  endtask

  task automatic set_cfg(input logic [31:0] si, input logic [31:0] st,
                         input logic [15:0] ns, input logic [15:0] dw);
    cfg_if.cfg_valid     = 1'b1;
    cfg_if.cfg_start_inc = si;
    cfg_if.cfg_step      = st;
    cfg_if.cfg_num_steps = ns;
    cfg_if.cfg_dwell     = dw;
  endtask

  logic [31:0] ramp_exp [6] = '{32'h1000, 32'h1000, 32'h1100, 32'h1100, 32'h1200, 32'h1200};
`ifdef DOPPLER_TRIANGLE_EN
  logic [31:0] tri_exp [5] = '{32'h0, 32'h10, 32'h20, 32'h10, 32'h0};
  localparam int TRI_N = 5;
`else
  logic [31:0] tri_exp [3] = '{32'h0, 32'h10, 32'h20};
  localparam int TRI_N = 3;
`endif

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; input_ready = 1'b0;
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_start_inc = '0; cfg_if.cfg_step = '0;
    cfg_if.cfg_num_steps = '0; cfg_if.cfg_dwell = '0;
    tick(); tick();
    chk("rst_phase", phase_inc, 0);
    chk("rst_nco", nco_en, 0);
    chk("rst_sv", shifted_valid, 0);
    chk("rst_idx", step_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cfg_ready", cfg_if.cfg_ready, 0);
    reset = 1'b0;
    tick();
    chk("idle_cfg_ready", cfg_if.cfg_ready, 1);

    // start with no profile loaded is ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("nocfg_busy", busy, 0);
    chk("nocfg_nco", nco_en, 0);

    // basic ramp, start with same-cycle cfg transfer, back-to-back samples
    set_cfg(32'h1000, 32'h100, 16'd3, 16'd2);
    start = 1'b1;
    tick();
    cfg_if.cfg_valid = 1'b0; start = 1'b0;
    chk("ramp_nco", nco_en, 1);
    chk("ramp_busy", busy, 1);
    chk("ramp_cfg_ready", cfg_if.cfg_ready, 0);
    input_ready = 1'b1;
    base = sv_cnt;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("ramp_phase%0d", k), phase_inc, ramp_exp[k]);
      tick();
    end
    input_ready = 1'b0;
    chk("ramp_drain_nco", nco_en, 0);
    chk("ramp_drain_busy", busy, 1);
    chk("ramp_drain_phase", phase_inc, 32'h1200);
    tick();
    chk("ramp_drain_done", done, 0);
    tick();
    chk("ramp_done", done, 1);
    chk("ramp_done_idx", step_idx, 2);
    tick();
    chk("ramp_idle_busy", busy, 0);
    chk("ramp_idle_done", done, 0);
    chk("ramp_sv_count", sv_cnt - base, 6);

    // negative step with wrap, cfg loaded before start
    set_cfg(32'h80, 32'hFFFF_FF00, 16'd2, 16'd1);
    tick();
    cfg_if.cfg_valid = 1'b0;
    chk("neg_cfg_only_busy", busy, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("neg_phase0", phase_inc, 32'h80);
    input_ready = 1'b1;
    tick();
    chk("neg_phase1", phase_inc, 32'hFFFF_FF80);
    chk("neg_idx1", step_idx, 1);
    tick();
    input_ready = 1'b0;
    chk("neg_drain_nco", nco_en, 0);
    chk("neg_drain_phase", phase_inc, 32'hFFFF_FF80);
    tick(); tick();
    chk("neg_done", done, 1);
    tick();

    // replay of the stored profile, then abort mid-RUN
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("replay_phase0", phase_inc, 32'h80);
    input_ready = 1'b1;
    tick();
    abort = 1'b1;
    base = done_cnt;
    tick();
    abort = 1'b0; input_ready = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_phase", phase_inc, 0);
    chk("abort_sv_cleared", shifted_valid, 0);
    tick(); tick(); tick();
    chk("abort_no_done", done_cnt - base, 0);

    // zero num_steps and dwell behave as one
    set_cfg(32'h55, 32'h7, 16'd0, 16'd0);
    start = 1'b1;
    tick();
    cfg_if.cfg_valid = 1'b0; start = 1'b0;
    input_ready = 1'b1;
    base = sv_cnt;
    tick();
    input_ready = 1'b0;
    chk("zero_drain_nco", nco_en, 0);
    chk("zero_drain_busy", busy, 1);
    chk("zero_phase", phase_inc, 32'h55);
    tick(); tick();
    chk("zero_done", done, 1);
    chk("zero_sv_count", sv_cnt - base, 1);
    tick();

    // sparse input: a strobe every third cycle, dwell of two
    set_cfg(32'h200, 32'h40, 16'd2, 16'd2);
    start = 1'b1;
    tick();
    cfg_if.cfg_valid = 1'b0; start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      input_ready = (c % 3 == 0);
      tick();
      chk($sformatf("sparse_sv%0d", c), shifted_valid, (c >= 1) && ((c - 1) % 3 == 0));
      chk($sformatf("sparse_phase%0d", c), phase_inc, (c >= 3) ? 32'h240 : 32'h200);
    end
    input_ready = 1'b0;
    chk("sparse_drain_nco", nco_en, 0);
    chk("sparse_idx", step_idx, 1);
    tick(); tick();
    chk("sparse_done", done, 1);
    tick();

    // reset mid-sweep clears the stored profile
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("mid_run_nco", nco_en, 1);
    reset = 1'b1;
    tick();
    chk("mid_rst_cfg_ready", cfg_if.cfg_ready, 0);
    reset = 1'b0;
    tick();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cfg_ready_after", cfg_if.cfg_ready, 1);
    chk("mid_rst_phase", phase_inc, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("mid_rst_start_ignored", busy, 0);

    // triangle profile (linear ramp only in the default build)
    set_cfg(32'h0, 32'h10, 16'd3, 16'd1);
    start = 1'b1;
    tick();
    cfg_if.cfg_valid = 1'b0; start = 1'b0;
    input_ready = 1'b1;
    for (int k = 0; k < TRI_N; k++) begin
      chk($sformatf("tri_phase%0d", k), phase_inc, tri_exp[k]);
      tick();
    end
    input_ready = 1'b0;
    chk("tri_drain_nco", nco_en, 0);
    tick(); tick();
    chk("tri_done", done, 1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/doppler_sweep_ctrl.md
# doppler_sweep_ctrl

Sequences the Frequency_Shifter datapath for Doppler emulation. Holds a programmed Doppler sweep profile, drives the NCO phase increment that produces the shifter's `cos`/`sin`, and steps that increment after a fixed number of input samples. Produces a valid strobe aligned to the shifter's registered outputs. Sits between the radar-control register interface and the NCO/Frequency_Shifter pair.

## Interface
- `SHIFT_LATENCY`, default 2: cycles from `input_ready` to valid `i_shited_val`/`q_shifted_val`.
- `INC_W`, default 32: NCO phase-increment width.
- `CNT_W`, default 16: step and dwell counter width.

- `M100CLK` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `cfg_valid` in 1: profile offered.
- `cfg_ready` out 1: high only in IDLE and not in reset; transfer when `cfg_valid & cfg_ready`.
- `cfg_start_inc` in INC_W: first phase increment (unsigned).
- `cfg_step` in INC_W: signed two's-complement increment delta.
- `cfg_num_steps` in CNT_W: number of increment values in the sweep; 0 is treated as 1.
- `cfg_dwell` in CNT_W: samples per increment value; 0 is treated as 1.
- `start` in 1: pulse to begin the sweep.
- `abort` in 1: pulse to stop immediately.
- `input_ready` in 1: sample strobe, the same signal that feeds the shifter.
- `phase_inc` out INC_W: to NCO.
- `nco_en` out 1: NCO advance enable.
- `shifted_valid` out 1: shifter output valid.
- `step_idx` out CNT_W: current step index.
- `busy` out 1: high when state is not IDLE.
- `done` out 1: one-cycle completion pulse.

## Operation
- **States:** IDLE, RUN, DRAIN, DONE.
- **IDLE:**
  - Accepts the profile into shadow registers and sets `cfg_loaded`.
  - `start` with `cfg_loaded = 0` and no same-cycle transfer is ignored.
  - `start` with a same-cycle cfg transfer uses the incoming values.
  - On start: go to RUN, `phase_inc <= start_inc`, `step_idx <= 0`, `dwell_cnt <= 0`.
- **RUN:**
  - `nco_en = 1`.
  - Each `input_ready` increments `dwell_cnt`.
  - On `input_ready` with `dwell_cnt == dwell-1`:
    - If `step_idx == num_steps-1`, go to DRAIN.
    - Otherwise `step_idx++`, `phase_inc <= phase_inc + cfg_step` (mod 2^INC_W, wrap permitted), `dwell_cnt <= 0`.
  - Cycles without `input_ready` change no counters.
- **DRAIN:**
  - `nco_en = 0` and `phase_inc` is held.
  - Waits SHIFT_LATENCY cycles, then goes to DONE.
- **DONE:** `done = 1` for one cycle, then IDLE. `cfg_loaded` stays set, so a repeat `start` replays the same profile.
- **`abort`:**
  - In RUN or DRAIN: next state IDLE, `phase_inc <= 0`, delay line cleared, no `done` pulse.
  - Has priority over all same-cycle events. Ignored in IDLE.
- **`shifted_valid`:** `input_ready & nco_en` delayed exactly SHIFT_LATENCY cycles through a shift register.
- **Reset values:** `phase_inc = 0`, `nco_en = 0`, `shifted_valid = 0`, `step_idx = 0`, `busy = 0`, `done = 0`, `cfg_ready = 0`; shadows 0, `cfg_loaded = 0`.
- **Reset mid-sweep:** same as reset; the next cycle is IDLE with `cfg_ready = 1`.

## Timing
- Start to RUN: `start` sampled on edge N; `nco_en` and `phase_inc` are valid from edge N+1.
- Step update: `phase_inc` updates on the edge that samples the dwell-completing `input_ready`, so it applies to the next sample.
- Valid latency: `shifted_valid` follows `input_ready` by SHIFT_LATENCY edges, matching the shifter's 2-register pipeline.
- Sweep completion: DRAIN lasts SHIFT_LATENCY cycles, so the last `shifted_valid` falls before or with the DONE cycle.
- `done` is asserted on the first cycle of DONE; `busy` drops the cycle after.
- Back-to-back input: `input_ready` every cycle is sustained with no bubbles.

## Configuration
- `DOPPLER_TRIANGLE_EN` defined: after the up-ramp's last step, the sweep continues with a down-ramp of another `num_steps-1` steps using `-cfg_step`, ending back at `start_inc`, then goes to DRAIN.
  - `step_idx` counts up through both ramps.
  - An extra internal `dir` flag is reset to up.
- `DOPPLER_TRIANGLE_EN` undefined: single linear ramp only.

## Structure
- Shared package `drfm_pkg`:
  - State enum.
  - INC_W, CNT_W and SHIFT_LATENCY defaults.
  - Sweep-config struct holding start_inc, step, num_steps and dwell.
- One sub-module, `valid_delay_line`: parameterised-depth 1-bit shift register with synchronous clear, used for `shifted_valid`.

## Test plan
- **Basic ramp:** cfg start_inc=0x1000, step=0x100, steps=3, dwell=2; start; `input_ready` every cycle → `phase_inc` 0x1000, 0x1000, 0x1100, 0x1100, 0x1200, 0x1200; `done` 2 cycles after the last sample; 6 `shifted_valid` pulses.
- **Negative step with wrap:** start_inc=0x00000080, step=-0x100, steps=2, dwell=1 → `phase_inc` 0x80 then 0xFFFFFF80.
- **Zero fields:** dwell=0, steps=0 → exactly one sample is processed, then DRAIN and `done`.
- **Sparse input:** `input_ready` every 3rd cycle, dwell=2 → a step occurs every 6 cycles; `shifted_valid` is 2 cycles after each strobe.
- **Abort and start gating:** `abort` mid-RUN → IDLE next cycle, `phase_inc=0`, no `done`, in-flight `shifted_valid` cleared. `start` issued after reset without config → ignored.
- **Triangle (`DOPPLER_TRIANGLE_EN`):** steps=3, step=0x10 → sequence 0, 0x10, 0x20, 0x10, 0 (start_inc=0).
